instruction_sequencer: RTL and testbench

- Multi-cycle control sequencer for the datapath.
- Owns the program counter and the instruction register; fetches 16-bit instruction words from program ROM.
- Presents the instruction to the existing decoder tree and receives its 55-bit ALU control word back.
- Steps the ALU, data memory, stack and register file through fetch / execute / wait / commit, handling variable-latency ALU ops and memory/stack handshakes.

---
 rtl/instruction_sequencer_pkg.sv | 56 +++++
 rtl/alu_control_word_decoder.sv | 24 ++
 rtl/instruction_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared control definitions for the instruction sequencer: FSM state
// encoding, load-source codes, ALU opcode constants and the layout of the
// 55-bit ALU control word produced by the decoder tree.
package instruction_sequencer_pkg;

  // Control word width and field placement.
  localparam int CW_WIDTH        = 55;
  localparam int CW_PC_INC_BIT   = 0;
  localparam int CW_ALU_OP_LSB   = 1;
  localparam int CW_ALU_OP_W     = 4;
  localparam int CW_LOAD_SRC_LSB = 5;
  localparam int CW_ST_MEM_BIT   = 7;
  localparam int CW_ST_STK_BIT   = 8;
  localparam int CW_USED_BITS    = 9;

  // Sequencer states.
  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    EXEC     = 3'd1,
    ALU_WAIT = 3'd2,
    MEM_WAIT = 3'd3,
    COMMIT   = 3'd4
  } seq_state_e;

  // Where the register-file write data comes from.
  typedef enum logic [1:0] {
    LS_NONE = 2'b00,
    LS_ALU  = 2'b01,
    LS_MEM  = 2'b10,
    LS_STK  = 2'b11
  } load_src_e;

  // ALU opcodes; IDIV..FDIV are the variable-latency ones.
  localparam logic [3:0] LEFT  = 4'd0;
  localparam logic [3:0] RIGHT = 4'd1;
  localparam logic [3:0] BXOR  = 4'd2;
  localparam logic [3:0] BAND  = 4'd3;
  localparam logic [3:0] IDIV  = 4'd4;
  localparam logic [3:0] FADD  = 4'd5;
  localparam logic [3:0] FSUB  = 4'd6;
  localparam logic [3:0] FMUL  = 4'd7;
  localparam logic [3:0] FDIV  = 4'd8;
  localparam logic [3:0] ADD   = 4'd9;
  localparam logic [3:0] SUB   = 4'd10;
  localparam logic [3:0] BOR   = 4'd11;
  localparam logic [3:0] MUL   = 4'd12;
  localparam logic [3:0] BNOT  = 4'd13;
  localparam logic [3:0] ITOF  = 4'd14;
  localparam logic [3:0] FTOI  = 4'd15;

  // True when the instruction has to visit data memory or the stack.
  function automatic logic needs_mem_access(load_src_e load_src, logic st_mem, logic st_stk);
    return (load_src == LS_MEM) || (load_src == LS_STK) || st_mem || st_stk;
  endfunction

endpackage

// File: rtl/alu_control_word_decoder.sv
// Extracts the fields the sequencer cares about from the 55-bit ALU control
// word. Remaining bits steer the datapath directly and are not used here.
module alu_control_word_decoder
  import instruction_sequencer_pkg::*;
(
  input  logic [CW_WIDTH-1:0] control_word,
  output logic                program_counter_increment,
  output logic [3:0]          alu_op,
  output logic [1:0]          alu_load_src,
  output logic                alu_store_to_mem,
  output logic                alu_store_to_stk
);

  logic unused_cw_bits;

  // Pure field slicing.
  assign program_counter_increment = control_word[CW_PC_INC_BIT];
  assign alu_op                    = control_word[CW_ALU_OP_LSB +: CW_ALU_OP_W];
  assign alu_load_src              = control_word[CW_LOAD_SRC_LSB +: 2];
  assign alu_store_to_mem          = control_word[CW_ST_MEM_BIT];
  assign alu_store_to_stk          = control_word[CW_ST_STK_BIT];
  assign unused_cw_bits            = ^control_word[CW_WIDTH-1:CW_USED_BITS];

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle control sequencer: owns PC and instruction register and walks
// each instruction through FETCH / EXEC / (ALU_WAIT) / (MEM_WAIT) / COMMIT.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC        = 16'h0000,
  parameter logic [15:0] MULTICYCLE_MASK = 16'h01F0,
  parameter int          WAIT_LIMIT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  output logic [15:0]         imem_addr,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         instruction,
  input  logic [CW_WIDTH-1:0] control_word,
  input  logic                branch_taken,
  input  logic [15:0]         branch_target,
  output logic                alu_start,
  input  logic                alu_done,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                stk_req,
  output logic                stk_we,
  input  logic                stk_ack,
  output logic                reg_write,
  output logic [15:0]         pc,
  output logic [15:0]         retired,
  output logic                fault
);

  localparam int                    WAIT_CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST  = WAIT_CNT_W'(WAIT_LIMIT - 1);

  seq_state_e            state_q, state_d;

  // Decoder outputs (valid in EXEC).
  logic                  dec_pc_inc;
  logic [3:0]            dec_alu_op;
  logic [1:0]            dec_load_src_raw;
  load_src_e             dec_load_src;
  logic                  dec_st_mem, dec_st_stk;

  // Fields captured in EXEC so later states do not depend on the decoders.
  logic                  held_pc_inc;
  load_src_e             held_load_src;
  logic                  held_st_mem, held_st_stk;

  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  instr_fault_q;

  load_src_e             issue_load_src;
  logic                  issue_st_mem, issue_st_stk;
  logic                  load_instr, capture_fields, raise_fault;
  logic                  wait_enter, mem_issue, mem_abort, do_commit;
  logic                  wait_expired, dmem_clear, stk_clear;
  logic [15:0]           pc_next;

  alu_control_word_decoder u_cw_decoder (
    .control_word              (control_word),
    .program_counter_increment (dec_pc_inc),
    .alu_op                    (dec_alu_op),
    .alu_load_src              (dec_load_src_raw),
    .alu_store_to_mem          (dec_st_mem),
    .alu_store_to_stk          (dec_st_stk)
  );

  assign dec_load_src = load_src_e'(dec_load_src_raw);
  assign wait_expired = (wait_cnt_q == WAIT_LAST);
  assign dmem_clear   = dmem_ack || !dmem_req;
  assign stk_clear    = stk_ack  || !stk_req;

  // Request flags come from the decoder in EXEC, from the held copy after ALU_WAIT.
  always_comb begin
    if (state_q == EXEC) begin
      issue_load_src = dec_load_src;
      issue_st_mem   = dec_st_mem;
      issue_st_stk   = dec_st_stk;
    end else begin
      issue_load_src = held_load_src;
      issue_st_mem   = held_st_mem;
      issue_st_stk   = held_st_stk;
    end
  end

  // PC for the next instruction: branch beats increment, otherwise hold.
  always_comb begin
    if (branch_taken)     pc_next = branch_target;
    else if (held_pc_inc) pc_next = pc + 16'd1;
    else                  pc_next = pc;
  end

  // The ROM registers its address, so the next PC is presented during COMMIT
  // (and RESET_PC during reset) to have the word ready in FETCH.
  assign imem_addr = reset ? RESET_PC : ((state_q == COMMIT) ? pc_next : pc);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d        = state_q;
    alu_start      = 1'b0;
    reg_write      = 1'b0;
    load_instr     = 1'b0;
    capture_fields = 1'b0;
    raise_fault    = 1'b0;
    wait_enter     = 1'b0;
    mem_issue      = 1'b0;
    mem_abort      = 1'b0;
    do_commit      = 1'b0;
    case (state_q)
      FETCH: begin
        load_instr = 1'b1;
        state_d    = EXEC;
      end
      EXEC: begin
        capture_fields = 1'b1;
        if (dec_st_mem && dec_st_stk) begin
          raise_fault = 1'b1;
          state_d     = COMMIT;
        end else if (MULTICYCLE_MASK[dec_alu_op]) begin
          alu_start  = 1'b1;
          wait_enter = 1'b1;
          state_d    = ALU_WAIT;
        end else if (needs_mem_access(dec_load_src, dec_st_mem, dec_st_stk)) begin
          wait_enter = 1'b1;
          mem_issue  = 1'b1;
          state_d    = MEM_WAIT;
        end else begin
          state_d = COMMIT;
        end
      end
      ALU_WAIT: begin
        if (alu_done) begin
          if (needs_mem_access(held_load_src, held_st_mem, held_st_stk)) begin
            wait_enter = 1'b1;
            mem_issue  = 1'b1;
            state_d    = MEM_WAIT;
          end else begin
            state_d = COMMIT;
          end
        end else if (wait_expired) begin
          raise_fault = 1'b1;
          state_d     = COMMIT;
        end
      end
      MEM_WAIT: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (dmem_clear && stk_clear) begin
          state_d = COMMIT;
        end else if (wait_expired) begin
          raise_fault = 1'b1;
          mem_abort   = 1'b1;
          state_d     = COMMIT;
        end
      end
      COMMIT: begin
        reg_write = (held_load_src != LS_NONE) && !instr_fault_q;
        do_commit = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Instruction register and captured control fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction   <= 16'h0000;
      held_pc_inc   <= 1'b0;
      held_load_src <= LS_NONE;
      held_st_mem   <= 1'b0;
      held_st_stk   <= 1'b0;
    end else begin
      if (load_instr) instruction <= imem_rdata;
      if (capture_fields) begin
        held_pc_inc   <= dec_pc_inc;
        held_load_src <= dec_load_src;
        held_st_mem   <= dec_st_mem;
        held_st_stk   <= dec_st_stk;
      end
    end
  end

  // Program counter and retired-instruction count advance only in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      retired <= 16'h0000;
    end else if (do_commit) begin
      pc      <= pc_next;
      retired <= retired + 16'd1;
    end
  end

  // Sticky fault plus a per-instruction copy that suppresses the write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault         <= 1'b0;
      instr_fault_q <= 1'b0;
    end else begin
      if (raise_fault) begin
        fault         <= 1'b1;
        instr_fault_q <= 1'b1;
      end else if (load_instr) begin
        instr_fault_q <= 1'b0;
      end
    end
  end

  // Shared wait counter: cleared on entry to a wait state, counts while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (wait_enter) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ALU_WAIT) || (state_q == MEM_WAIT)) begin
      wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
    end
  end

  // Registered memory/stack requests: raised on entry to MEM_WAIT, each one
  // dropped after its own ack, both dropped on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      stk_req  <= 1'b0;
      stk_we   <= 1'b0;
    end else if (mem_issue) begin
      dmem_req <= (issue_load_src == LS_MEM) || issue_st_mem;
      dmem_we  <= issue_st_mem;
      stk_req  <= (issue_load_src == LS_STK) || issue_st_stk;
      stk_we   <= issue_st_stk;
    end else if (state_q == MEM_WAIT) begin
      if (dmem_ack || mem_abort) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end
      if (stk_ack || mem_abort) begin
        stk_req <= 1'b0;
        stk_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer. The bench provides a synchronous
// program ROM, a stand-in decoder (instruction bits map onto control-word
// fields), a branch unit and simple ack/done responders.
//   instruction[3:0] alu_op, [5:4] load_src, [6] store_to_mem,
//   [7] store_to_stk, [14] branch, [15] halt (no pc increment).
module tb_instruction_sequencer;

  localparam int WL = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_addr, imem_rdata, instruction;
  logic [54:0] control_word;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        alu_start, alu_done;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        stk_req, stk_we, stk_ack;
  logic        reg_write;
  logic [15:0] pc, retired;
  logic        fault;

  logic [15:0] rom [0:65535];
  logic [15:0] br_target;
  int          dmem_lat, stk_lat, alu_lat;
  int          dmem_cnt, stk_cnt, alu_cnt;
  logic        alu_armed, alu_force;
  int          vectors = 0;
  int          miscompares = 0;
  logic [5:0]  strobes;

  instruction_sequencer #(
    .RESET_PC        (16'h0000),
    .MULTICYCLE_MASK (16'h01F0),
    .WAIT_LIMIT      (WL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .control_word  (control_word),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .alu_start     (alu_start),
    .alu_done      (alu_done),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .stk_req       (stk_req),
    .stk_we        (stk_we),
    .stk_ack       (stk_ack),
    .reg_write     (reg_write),
    .pc            (pc),
    .retired       (retired),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  function automatic logic [54:0] decode(input logic [15:0] i);
    return {{23{2'b10}}, i[7], i[6], i[5:4], i[3:0], ~i[15]};
  endfunction

  assign control_word  = decode(instruction);
  assign branch_taken  = instruction[14];
  assign branch_target = br_target;
  assign strobes       = {alu_start, dmem_req, dmem_we, stk_req, stk_we, reg_write};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next sampling point and update the responders.
  task automatic tick();
    @(negedge clk);
    if (dmem_req) dmem_cnt++; else dmem_cnt = 0;
    dmem_ack = dmem_req && (dmem_cnt == dmem_lat);
    if (stk_req) stk_cnt++; else stk_cnt = 0;
    stk_ack = stk_req && (stk_cnt == stk_lat);
    if (alu_start) begin
      alu_armed = 1'b1;
      alu_cnt   = 0;
    end else if (alu_armed) begin
      alu_cnt++;
    end
    alu_done = alu_force || (alu_armed && !alu_start && alu_cnt == alu_lat);
    if (alu_armed && !alu_start && alu_cnt == alu_lat) alu_armed = 1'b0;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 65536; a++) rom[a] = 16'h0000;
  endtask

  // Two reset cycles; returns at the sample point of the first FETCH (cycle 0).
  task automatic do_reset();
    reset     = 1'b1;
    dmem_lat  = -1; stk_lat = -1; alu_lat = -1;
    dmem_cnt  = 0;  stk_cnt = 0;  alu_cnt = 0;
    alu_armed = 1'b0; alu_force = 1'b0;
    dmem_ack  = 1'b0; stk_ack = 1'b0; alu_done = 1'b0;
    br_target = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    vectors++;
    if (pc !== 16'h0000 || instruction !== 16'h0000 || retired !== 16'h0000 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs got pc=%h ir=%h ret=%h fault=%b exp 0000 0000 0000 0", pc, instruction, retired, fault);
    end
    vectors++;
    if (strobes !== 6'b0 || imem_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outs got strobes=%b addr=%h exp 000000 0000", strobes, imem_addr);
    end
  endtask

  task automatic test_noop_stream();
    clear_rom();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      vectors++;
      if (pc !== 16'(c / 3) || retired !== 16'(c / 3)) begin
        miscompares++;
        $display("FAIL noop_pc c=%0d got pc=%h ret=%h exp %h", c, pc, retired, 16'(c / 3));
      end
      vectors++;
      if (strobes !== 6'b0) begin
        miscompares++;
        $display("FAIL noop_strobes c=%0d got %b exp 000000", c, strobes);
      end
    end
  endtask

  task automatic test_single_cycle_alu();
    clear_rom();
    rom[0] = 16'h0012;              // LDSW BXOR, load_src=ALU
    do_reset();
    alu_force = 1'b1;               // stray done must be ignored
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      vectors++;
      if (strobes !== {5'b0, c == 2}) begin
        miscompares++;
        $display("FAIL sc_strobes c=%0d got %b exp %b", c, strobes, {5'b0, c == 2});
      end
    end
    vectors++;
    if (pc !== 16'h0001 || retired !== 16'h0001 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL sc_pc got pc=%h ret=%h fault=%b exp 0001 0001 0", pc, retired, fault);
    end
    alu_force = 1'b0;
  endtask

  task automatic test_multicycle_alu();
    clear_rom();
    rom[0] = 16'h0014;              // IDIV, load_src=ALU
    do_reset();
    alu_lat = 5;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      vectors++;
      if (strobes !== {c == 1, 4'b0, c == 7}) begin
        miscompares++;
        $display("FAIL mc_strobes c=%0d got %b exp %b", c, strobes, {c == 1, 4'b0, c == 7});
      end
      if (c == 7 || c == 8) begin
        vectors++;
        if (retired !== 16'(c - 7)) begin
          miscompares++;
          $display("FAIL mc_retired c=%0d got %h exp %h", c, retired, 16'(c - 7));
        end
      end
    end
    vectors++;
    if (pc !== 16'h0001) begin
      miscompares++;
      $display("FAIL mc_pc got %h exp 0001", pc);
    end
  endtask

  task automatic test_mem_stack();
    logic d, s;
    clear_rom();
    rom[0] = 16'h0040;              // WMEM
    rom[1] = 16'h0030;              // RSTK, load_src=STK
    do_reset();
    dmem_lat = 3;
    stk_lat  = 1;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) tick();
      d = (c >= 2 && c <= 4);
      s = (c == 8);
      vectors++;
      if (strobes !== {1'b0, d, d, s, 1'b0, c == 9}) begin
        miscompares++;
        $display("FAIL mem_strobes c=%0d got %b exp %b", c, strobes, {1'b0, d, d, s, 1'b0, c == 9});
      end
    end
    vectors++;
    if (pc !== 16'h0002 || retired !== 16'h0002) begin
      miscompares++;
      $display("FAIL mem_pc got pc=%h ret=%h exp 0002 0002", pc, retired);
    end
  endtask

  task automatic test_wrap_branch();
    clear_rom();
    rom[0]       = 16'h4000;        // branch, pc_inc set
    rom[16'hFFFF] = 16'h0000;       // noop at top of memory
    rom[16'h0040] = 16'h8000;       // halt: no increment
    do_reset();
    br_target = 16'hFFFF;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) tick();
      if (c == 6) br_target = 16'h0040;
      if (c == 3) begin
        vectors++;
        if (pc !== 16'hFFFF || imem_addr !== 16'hFFFF) begin
          miscompares++;
          $display("FAIL br_to_ffff got pc=%h addr=%h exp ffff ffff", pc, imem_addr);
        end
      end
      if (c == 6) begin
        vectors++;
        if (pc !== 16'h0000) begin
          miscompares++;
          $display("FAIL pc_wrap got %h exp 0000", pc);
        end
      end
      if (c == 9) begin
        vectors++;
        if (pc !== 16'h0040) begin
          miscompares++;
          $display("FAIL br_override got %h exp 0040", pc);
        end
      end
      if (c == 13) begin
        vectors++;
        if (pc !== 16'h0040 || retired !== 16'h0004 || instruction !== 16'h8000) begin
          miscompares++;
          $display("FAIL halt_hold got pc=%h ret=%h ir=%h exp 0040 0004 8000", pc, retired, instruction);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic d, w;
    clear_rom();
    rom[0] = 16'h0040;              // WMEM, never acked
    rom[1] = 16'h0020;              // load from memory, never acked
    rom[2] = 16'h0012;              // LDSW after the faults
    do_reset();
    for (int c = 0; c < 520; c++) begin
      if (c > 0) tick();
      w = (c >= 2 && c <= 2 + WL - 1);
      d = w || (c >= 260 && c <= 260 + WL - 1);
      vectors++;
      if (strobes !== {1'b0, d, w, 2'b0, c == 518}) begin
        miscompares++;
        $display("FAIL to_strobes c=%0d got %b exp %b", c, strobes, {1'b0, d, w, 2'b0, c == 518});
      end
      if (c == 256 || c == 257 || c == 519) begin
        vectors++;
        if (fault !== (c != 256)) begin
          miscompares++;
          $display("FAIL to_fault c=%0d got %b exp %b", c, fault, c != 256);
        end
      end
    end
    vectors++;
    if (pc !== 16'h0003 || retired !== 16'h0003) begin
      miscompares++;
      $display("FAIL to_pc got pc=%h ret=%h exp 0003 0003", pc, retired);
    end
  endtask

  task automatic test_illegal_cw();
    clear_rom();
    rom[0] = 16'h00F0;              // both store flags, load_src=STK
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      vectors++;
      if (strobes !== 6'b0 || fault !== (c >= 2)) begin
        miscompares++;
        $display("FAIL ill_c%0d got strobes=%b fault=%b exp 000000 %b", c, strobes, fault, c >= 2);
      end
    end
    vectors++;
    if (pc !== 16'h0001) begin
      miscompares++;
      $display("FAIL ill_pc got %h exp 0001", pc);
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_rom();
    rom[0] = 16'h0000;
    rom[1] = 16'h0040;              // WMEM, never acked
    do_reset();
    for (int c = 1; c <= 6; c++) tick();
    vectors++;
    if (dmem_req !== 1'b1 || pc !== 16'h0001) begin
      miscompares++;
      $display("FAIL rst_pre got req=%b pc=%h exp 1 0001", dmem_req, pc);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || pc !== 16'h0000 || retired !== 16'h0000 || instruction !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_mid got req=%b we=%b pc=%h ret=%h ir=%h exp 0 0 0000 0000 0000",
               dmem_req, dmem_we, pc, retired, instruction);
    end
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    vectors++;
    if (pc !== 16'h0001 || retired !== 16'h0001 || strobes !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_resume got pc=%h ret=%h strobes=%b exp 0001 0001 000000", pc, retired, strobes);
    end
  endtask

  initial begin
    test_reset();
    test_noop_stream();
    test_single_cycle_alu();
    test_multicycle_alu();
    test_mem_stack();
    test_wrap_branch();
    test_timeout();
    test_illegal_cw();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
